booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Iterative signed N×N multiplier for the MUL/HI-LO path.
- Generates two radix-4 Booth partial products per cycle.
- Each cycle, a single 4:2 carry-save reducer combines those two products with the (sum, carry) accumulator.
- A final carry-propagate cycle resolves the 2N-bit product into HI/LO registers.

Parameters:
- N, 32, operand width; must be a multiple of 4 (N/4 accumulate iterations).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request; sampled only when o_busy=0.
- i_a  input  N  multiplicand, signed two's complement.
- i_b  input  N  multiplier, signed two's complement.
- o_busy  output  1  high while an operation is in flight.
- o_valid  output  1  one-cycle pulse when o_hi/o_lo update.
- o_hi  output  N  product bits [2N-1:N].
- o_lo  output  N  product bits [N-1:0].

Behaviour:
- Reset (async, rst=1): state=IDLE; o_busy=0, o_valid=0, o_hi=0, o_lo=0; accumulator, correction vector and iteration counter cleared. Reset mid-operation aborts with no o_valid pulse.
- IDLE: i_start=1 at an edge latches i_a/i_b. The same edge clears acc_sum/acc_carry/corr (2N bits each), sets iter=0, enters ACC and sets o_busy=1.
- ACC (N/4 cycles), for iteration i, digits k=2i and k=2i+1:
  - Booth triplet is {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0.
  - Digit map: 000,111→0; 001,010→+1; 011→+2; 100→-2; 101,110→-1.
  - Partial product pp_k is the 2N-bit sign-extended |d|·A, shifted left by 2k.
  - Negative digit: pp_k = (~(|d|·A sign-extended)) << 2k, zeros below bit 2k, and bit 2k of corr is set. Correction bit positions are disjoint across digits, so corr accumulates by OR.
  - Reducer inputs are {acc_sum, acc_carry, pp_2i, pp_2i+1}, carry-in tied 0.
  - Reducer outputs are truncated to 2N bits (modulo 2^2N) and written back to acc_sum/acc_carry.
  - iter increments each cycle; when iter reaches N/4-1, next state is FINAL.
- FINAL (1 cycle): {o_hi,o_lo} <= acc_sum + acc_carry + corr (mod 2^2N); o_valid=1 for this cycle only; o_busy=0; next state IDLE.
- Latency: start sampled at edge E0; o_valid and new o_hi/o_lo appear after edge E(N/4+1), i.e. edge E9 for N=32. Throughput is one result per N/4+2 cycles.
- i_start while o_busy=1 is ignored; operands are not re-latched.
- i_start high during the o_valid cycle is accepted (state is IDLE), giving back-to-back operation.
- o_hi/o_lo hold their value until the next FINAL or reset.
- Operand inputs are don't-care except at the accept edge.
- Result equals the exact signed 2N-bit product for all inputs, including -2^(N-1)×-2^(N-1).

Decomposition:
- Shared package mul_pkg holds:
  - state encoding (IDLE, ACC, FINAL);
  - Booth digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2);
  - a localparam for the iteration count, N/4.
- Sub-module booth_pp_gen (combinational): takes A, a 3-bit triplet and the digit index, and emits the 2N-bit shifted pp plus its correction bit. Instantiate it twice per cycle.
- The existing 4:2 reducer is instantiated once at width 2N.

Test Plan:
- a=3, b=5 -> o_valid 9 cycles after start; o_hi=0x00000000, o_lo=0x0000000F.
- a=0xFFFFFFFF, b=0xFFFFFFFF (-1×-1) -> o_hi=0x00000000, o_lo=0x00000001.
- a=0x80000000, b=0x80000000 -> o_hi=0x40000000, o_lo=0x00000000; a=0x7FFFFFFF, b=0x80000000 -> o_hi=0xC0000000, o_lo=0x80000000.
- Start a=2, b=7, then pulse i_start with a=9, b=9 three cycles later -> single o_valid, o_lo=0x0000000E, o_busy held high throughout.
- Start a=6, b=-4; assert rst at cycle 4 -> o_busy/o_hi/o_lo immediately 0, no o_valid. After release, a=6, b=-4 yields o_hi=0xFFFFFFFF, o_lo=0xFFFFFFE8.
- 1000 random signed pairs, back-to-back with i_start held high -> each o_valid result matches the 64-bit signed reference product; o_valid spacing is exactly 10 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mul_pkg;

  localparam int unsigned MUL_N    = 32;
  localparam int unsigned ITER_CNT = MUL_N / 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FINAL
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  function automatic booth_digit_e booth_decode(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: sign-extended |d|*A shifted by 2k,
// one's-complemented for negative digits with the +1 returned as corr_o.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned KW = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [2:0]     trip_i,
  input  logic [KW-1:0]  k_i,
  output logic [2*N-1:0] pp_o,
  output logic           corr_o
);

  localparam int unsigned W = 2 * N;

  logic [W-1:0]  a_ext;
  logic [W-1:0]  mag;
  logic [KW:0]   sh;
  booth_digit_e  digit;

  assign a_ext = {{N{a_i[N-1]}}, a_i};
  assign sh    = {k_i, 1'b0};
  assign digit = booth_decode(trip_i);

  always_comb begin
    mag    = '0;
    pp_o   = '0;
    corr_o = 1'b0;
    case (digit)
      POS1, NEG1: mag = a_ext;
      POS2, NEG2: mag = a_ext << 1;
      default:    mag = '0;
    endcase
    // Shifting in zeros below bit 2k keeps the +1 correction at exactly bit 2k.
    if (digit == NEG1 || digit == NEG2) begin
      pp_o   = (~mag) << sh;
      corr_o = 1'b1;
    end else begin
      pp_o   = mag << sh;
    end
  end

endmodule

// File: rtl/csa42.sv
// 4:2 carry-save reducer (two chained 3:2 stages), carry-in tied low, mod 2^W.
module csa42 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] x0_i,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  input  logic [W-1:0] x3_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] s1;
  logic [W-1:0] c1;
  logic [W-1:0] maj1;
  logic [W-1:0] maj2;

  assign s1      = x0_i ^ x1_i ^ x2_i;
  assign maj1    = (x0_i & x1_i) | (x0_i & x2_i) | (x1_i & x2_i);
  assign c1      = {maj1[W-2:0], 1'b0};
  assign sum_o   = s1 ^ x3_i ^ c1;
  assign maj2    = (s1 & x3_i) | (s1 & c1) | (x3_i & c1);
  assign carry_o = {maj2[W-2:0], 1'b0};

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative signed NxN multiplier: two Booth digits per cycle reduced into a
// carry-save accumulator, then one carry-propagate cycle into HI/LO.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_valid,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo
);

  localparam int unsigned W     = 2 * N;
  localparam int unsigned ITERS = ITER_CNT * N / MUL_N;
  localparam int unsigned ITW   = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int unsigned KW    = ITW + 1;

  state_e         state_q;
  logic [N-1:0]   a_q;
  logic [N:0]     b_sh_q;
  logic [ITW-1:0] iter_q;
  logic [W-1:0]   acc_sum_q, acc_carry_q, corr_q;
  logic           busy_q, valid_q;
  logic [N-1:0]   hi_q, lo_q;

  logic [KW-1:0]  k0, k1;
  logic [W-1:0]   pp0, pp1;
  logic           c0, c1;
  logic [W-1:0]   acc_sum_d, acc_carry_d, corr_d, prod_d;

  assign k0 = {iter_q, 1'b0};
  assign k1 = {iter_q, 1'b1};

  // b_sh_q carries the implicit b[-1]=0 in bit 0 and shifts four bits per iteration.
  booth_pp_gen #(.N(N), .KW(KW)) u_pp0 (
    .a_i    (a_q),
    .trip_i (b_sh_q[2:0]),
    .k_i    (k0),
    .pp_o   (pp0),
    .corr_o (c0)
  );

  booth_pp_gen #(.N(N), .KW(KW)) u_pp1 (
    .a_i    (a_q),
    .trip_i (b_sh_q[4:2]),
    .k_i    (k1),
    .pp_o   (pp1),
    .corr_o (c1)
  );

  csa42 #(.W(W)) u_csa (
    .x0_i    (acc_sum_q),
    .x1_i    (acc_carry_q),
    .x2_i    (pp0),
    .x3_i    (pp1),
    .sum_o   (acc_sum_d),
    .carry_o (acc_carry_d)
  );

  assign corr_d = corr_q | (W'(c0) << {k0, 1'b0}) | (W'(c1) << {k1, 1'b0});
  assign prod_d = acc_sum_q + acc_carry_q + corr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_sh_q      <= '0;
      iter_q      <= '0;
      acc_sum_q   <= '0;
      acc_carry_q <= '0;
      corr_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            a_q         <= i_a;
            b_sh_q      <= {i_b, 1'b0};
            iter_q      <= '0;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            corr_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= ACC;
          end
        end
        ACC: begin
          acc_sum_q   <= acc_sum_d;
          acc_carry_q <= acc_carry_d;
          corr_q      <= corr_d;
          iter_q      <= iter_q + ITW'(1);
          b_sh_q      <= {4'b0000, b_sh_q[N:4]};
          if (iter_q == ITW'(ITERS - 1)) state_q <= FINAL;
        end
        FINAL: begin
          hi_q    <= prod_d[W-1:N];
          lo_q    <= prod_d[N-1:0];
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;

endmodule
